// File: rtl/clkmeas.sv
// Measures period and high time of an asynchronous square wave in clk_in cycles, with lock and timeout flags.
// Latency: valid two edges after the edge that first samples a sig_in rise. A pulse output with no backpressure.
module clkmeas #(
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, MEASURE, TMO} state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             rise;
  logic [CNT_W-1:0] per_cnt, per_nxt;
  logic [CNT_W-1:0] hi_cnt, hi_nxt;
  logic [CNT_W-1:0] period_nxt, high_nxt;
  logic             valid_nxt, locked_nxt, timeout_nxt;
  logic [MW-1:0]    match_cnt, match_nxt;
  logic             have_prev, prev_nxt;
  logic             is_match;

  assign rise     = s2 & ~s3;
  assign is_match = have_prev && (per_cnt == period_out) && (hi_cnt == high_out);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      period_out <= '0;
      high_out   <= '0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
      match_cnt  <= '0;
      have_prev  <= 1'b0;
    end else begin
      state      <= state_nxt;
      per_cnt    <= per_nxt;
      hi_cnt     <= hi_nxt;
      period_out <= period_nxt;
      high_out   <= high_nxt;
      valid      <= valid_nxt;
      locked     <= locked_nxt;
      timeout    <= timeout_nxt;
      match_cnt  <= match_nxt;
      have_prev  <= prev_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    per_nxt     = per_cnt;
    hi_nxt      = hi_cnt;
    period_nxt  = period_out;
    high_nxt    = high_out;
    valid_nxt   = 1'b0;
    locked_nxt  = locked;
    timeout_nxt = timeout;
    match_nxt   = match_cnt;
    prev_nxt    = have_prev;
    case (state)
      IDLE, TMO: begin
        // First rise only opens a measurement window; nothing to report yet.
        if (rise) begin
          state_nxt   = MEASURE;
          per_nxt     = CNT_W'(1);
          hi_nxt      = CNT_W'(1);
          timeout_nxt = 1'b0;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_nxt = per_cnt;
          high_nxt   = hi_cnt;
          valid_nxt  = 1'b1;
          per_nxt    = CNT_W'(1);
          hi_nxt     = CNT_W'(1);
          prev_nxt   = 1'b1;
          if (is_match)
            match_nxt = (match_cnt == LOCK_MAX) ? match_cnt : match_cnt + MW'(1);
          else
            match_nxt = '0;
          locked_nxt = (match_nxt == LOCK_MAX);
        end else begin
          per_nxt = per_cnt + CNT_W'(1);
          hi_nxt  = hi_cnt + CNT_W'(s2);
          // A rise on the all-ones count takes the branch above, so it is reported instead.
          if (&per_cnt) begin
            state_nxt   = TMO;
            timeout_nxt = 1'b1;
            locked_nxt  = 1'b0;
            match_nxt   = '0;
            prev_nxt    = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_clkmeas.sv
// Directed bench for clkmeas (CNT_W=8, LOCK_CNT=3): cycle-accurate waveforms with hand-computed results.
module tb_clkmeas;

  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst_n  = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             valid;
  logic             locked;
  logic             timeout;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int nval = 0;
  int last_vcyc = 0;
  int vgap = 0;
  int v_per = 0;
  int v_hi = 0;
  int v_lock = 0;
  int to_ticks = 0;

  clkmeas #(.CNT_W(CNT_W), .LOCK_CNT(3)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .period_out (period_out),
    .high_out   (high_out),
    .valid      (valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    if (timeout) to_ticks++;
    if (valid) begin
      if (nval > 0) vgap = cyc - last_vcyc;
      nval++;
      last_vcyc = cyc;
      v_per  = int'(period_out);
      v_hi   = int'(high_out);
      v_lock = int'(locked);
    end
  endtask

  task automatic wave(input int per, input int hi, input int n);
    for (int p = 0; p < n; p++)
      for (int c = 0; c < per; c++) begin
        sig_in = (c < hi);
        tick();
      end
  endtask

  initial begin
    int nz;
    int cyc0;
    int nv0;
    int to_cyc;
    int to_lock;

    // Reset state
    tick();
    tick();
    check("rst_period", period_out, 0);
    check("rst_high", high_out, 0);
    check("rst_valid", valid, 0);
    check("rst_locked", locked, 0);
    check("rst_timeout", timeout, 0);
    rst_n = 1'b1;

    // IDLE never times out
    nz = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (valid || locked || timeout || period_out != 0 || high_out != 0) nz++;
    end
    check("idle_nonzero_cycles", nz, 0);

    // Divide-by-8: first valid at second rise, lock on 4th valid
    cyc0 = cyc;
    wave(8, 4, 1);
    check("div8_no_valid_first_rise", nval, 0);
    wave(8, 4, 1);
    check("div8_first_valid_cnt", nval, 1);
    check("div8_first_valid_latency", last_vcyc - cyc0, 11);
    check("div8_period", v_per, 8);
    check("div8_high", v_hi, 4);
    wave(8, 4, 2);
    check("div8_nval_3", nval, 3);
    check("div8_unlocked_3rd", locked, 0);
    wave(8, 4, 1);
    check("div8_nval_4", nval, 4);
    check("div8_locked_4th", v_lock, 1);
    check("div8_gap", vgap, 8);

    // Switch to 10/5: first valid still reports the last 8/4 period
    wave(10, 5, 1);
    check("sw_trans_period", v_per, 8);
    check("sw_trans_locked", v_lock, 1);
    wave(10, 5, 1);
    check("sw_period", v_per, 10);
    check("sw_high", v_hi, 5);
    check("sw_lock_dropped", v_lock, 0);
    wave(10, 5, 2);
    check("sw_unlocked_2nd", locked, 0);
    wave(10, 5, 1);
    check("sw_relocked_3rd", v_lock, 1);
    check("sw_nval", nval, 9);

    // Timeout 255 edges after the last valid
    to_cyc = 0;
    to_lock = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (timeout) begin
        to_cyc = cyc;
        to_lock = int'(locked);
        break;
      end
    end
    check("to_delay", to_cyc - last_vcyc, 255);
    check("to_locked_cleared", to_lock, 0);
    nv0 = nval;
    wave(10, 5, 1);
    check("to_cleared", timeout, 0);
    check("to_no_valid_first_rise", nval, nv0);
    wave(10, 5, 1);
    check("to_recover_valid", nval, nv0 + 1);
    check("to_recover_period", v_per, 10);
    check("to_recover_high", v_hi, 5);

    // Toggle every cycle
    nv0 = nval;
    wave(2, 1, 20);
    check("tog_nval", nval - nv0, 19);
    check("tog_period", v_per, 2);
    check("tog_high", v_hi, 1);
    check("tog_gap", vgap, 2);

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    check("arst_period", period_out, 0);
    check("arst_high", high_out, 0);
    check("arst_flags", {valid, locked, timeout}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    nv0 = nval;
    wave(2, 1, 2);
    check("arst_no_valid_early", nval, nv0);
    wave(2, 1, 1);
    check("arst_valid_2nd_rise", nval, nv0 + 1);
    check("arst_period_after", v_per, 2);

    // 16-cycle period, narrow then wide high time
    wave(16, 1, 3);
    check("p16_h1_period", v_per, 16);
    check("p16_h1_high", v_hi, 1);
    wave(16, 15, 3);
    check("p16_h15_period", v_per, 16);
    check("p16_h15_high", v_hi, 15);

    // Rise on the all-ones count is reported, not timed out
    to_ticks = 0;
    wave(255, 100, 3);
    check("p255_period", v_per, 255);
    check("p255_high", v_hi, 100);
    check("p255_no_timeout", to_ticks, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
